// File: rtl/wbu_commit_pkg.sv
// Shared types and constants for the write-back/commit stage.
// Defaults here size the standard core configuration.
package wbu_commit_pkg;

    localparam int NUM_CH_DEF      = 2;
    localparam int SEQ_W_DEF       = 4;
    localparam int XLEN_DEF        = 64;
    localparam int IRQ_NUM_DEF     = 6;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [SEQ_W_DEF-1:0] seq_t;

    // Synchronous exception causes as reported on commit_cause.
    localparam logic [XLEN_DEF-1:0] CAUSE_INSN_MISALIGNED = 64'd0;
    localparam logic [XLEN_DEF-1:0] CAUSE_INSN_FAULT      = 64'd1;
    localparam logic [XLEN_DEF-1:0] CAUSE_ILLEGAL_INSN    = 64'd2;
    localparam logic [XLEN_DEF-1:0] CAUSE_BREAKPOINT      = 64'd3;
    localparam logic [XLEN_DEF-1:0] CAUSE_LOAD_FAULT      = 64'd5;
    localparam logic [XLEN_DEF-1:0] CAUSE_STORE_FAULT     = 64'd7;
    localparam logic [XLEN_DEF-1:0] CAUSE_ECALL_U         = 64'd8;
    localparam logic [XLEN_DEF-1:0] CAUSE_ECALL_S         = 64'd9;
    localparam logic [XLEN_DEF-1:0] CAUSE_ECALL_M         = 64'd11;

    // Bit positions of the interrupt lines in irq_asyn / irq_syn.
    localparam int IRQ_MSIP = 0;
    localparam int IRQ_MEIP = 1;
    localparam int IRQ_MTIP = 2;
    localparam int IRQ_SSIP = 3;
    localparam int IRQ_SEIP = 4;
    localparam int IRQ_STIP = 5;

endpackage

// File: rtl/wbu_commit_if.sv
// Result-channel bundle between the execution units and the commit stage.
// Fields are flattened per channel, channel i occupying slice i.
interface wbu_commit_if #(
    parameter int NUM_CH = 2,
    parameter int SEQ_W  = 4,
    parameter int XLEN   = 64
);

    logic [NUM_CH-1:0]       valid;
    logic [NUM_CH-1:0]       ready;
    logic [NUM_CH*SEQ_W-1:0] seq;
    logic [NUM_CH*XLEN-1:0]  pc;
    logic [NUM_CH*5-1:0]     rd;
    logic [NUM_CH-1:0]       dest_wen;
    logic [NUM_CH*XLEN-1:0]  data;
    logic [NUM_CH-1:0]       trap_valid;
    logic [NUM_CH*XLEN-1:0]  trap_cause;

    modport master (
        output valid, seq, pc, rd, dest_wen, data, trap_valid, trap_cause,
        input  ready
    );

    modport slave (
        input  valid, seq, pc, rd, dest_wen, data, trap_valid, trap_cause,
        output ready
    );

endinterface

// File: rtl/wbu_hold_slot.sv
// Holding slot for one result channel: captures an offered result and
// keeps it until it retires or the pipeline is flushed.
module wbu_hold_slot #(
    parameter int SEQ_W = 4,
    parameter int XLEN  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             clear,
    input  logic             flush,
    input  logic [SEQ_W-1:0] load_seq,
    input  logic [XLEN-1:0]  load_pc,
    input  logic [4:0]       load_rd,
    input  logic             load_dest_wen,
    input  logic [XLEN-1:0]  load_data,
    input  logic             load_trap,
    input  logic [XLEN-1:0]  load_cause,
    output logic             hold_v,
    output logic [SEQ_W-1:0] seq,
    output logic [XLEN-1:0]  pc,
    output logic [4:0]       rd,
    output logic             dest_wen,
    output logic [XLEN-1:0]  data,
    output logic             trap,
    output logic [XLEN-1:0]  cause
);

    // Capture wins over clear so a retiring slot reloads in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v <= 1'b0;
        end else if (flush) begin
            hold_v <= 1'b0;
        end else if (capture) begin
            hold_v <= 1'b1;
        end else if (clear) begin
            hold_v <= 1'b0;
        end
    end

    // NOTE: payload is deliberately not reset; hold_v alone qualifies it.
    always_ff @(posedge clk) begin
        if (capture) begin
            seq      <= load_seq;
            pc       <= load_pc;
            rd       <= load_rd;
            dest_wen <= load_dest_wen;
            data     <= load_data;
            trap     <= load_trap;
            cause    <= load_cause;
        end
    end

endmodule

// File: rtl/wbu_sync.sv
// One flop stage of an interrupt synchroniser; chain instances for depth.
module wbu_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking so each chained stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/wbu_commit.sv
// Multi-channel commit stage: retires one result per cycle in tag order,
// drives the GPR write and CSR commit ports, flush, and synchronised IRQs.
module wbu_commit
    import wbu_commit_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int SEQ_W       = SEQ_W_DEF,
    parameter int XLEN        = XLEN_DEF,
    parameter int IRQ_NUM     = IRQ_NUM_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    wbu_commit_if.slave        ch,
    input  logic               csr_jump_flag,
    input  logic [IRQ_NUM-1:0] irq_asyn,
    output logic [IRQ_NUM-1:0] irq_syn,
    output logic               gpr_wen,
    output logic [4:0]         gpr_rd,
    output logic [XLEN-1:0]    gpr_wdata,
    output logic               commit_valid,
    output logic [XLEN-1:0]    commit_pc,
    output logic               commit_trap,
    output logic [XLEN-1:0]    commit_cause,
    output logic               flush_flag,
    output logic [SEQ_W-1:0]   exp_seq
);

    logic [NUM_CH-1:0] hold_v;
    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] slot_dest_wen;
    logic [NUM_CH-1:0] slot_trap;
    logic [SEQ_W-1:0]  slot_seq   [NUM_CH];
    logic [XLEN-1:0]   slot_pc    [NUM_CH];
    logic [4:0]        slot_rd    [NUM_CH];
    logic [XLEN-1:0]   slot_data  [NUM_CH];
    logic [XLEN-1:0]   slot_cause [NUM_CH];

    logic              sel_dest_wen;
    logic [4:0]        sel_rd;
    logic [XLEN-1:0]   sel_data;

    assign flush_flag = csr_jump_flag;

    // A channel may refill when its slot is empty or is retiring right now.
    assign ch.ready = {NUM_CH{~flush_flag}} & (~hold_v | grant);
    assign capture  = ch.valid & ch.ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        wbu_hold_slot #(
            .SEQ_W (SEQ_W),
            .XLEN  (XLEN)
        ) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .capture       (capture[i]),
            .clear         (grant[i]),
            .flush         (flush_flag),
            .load_seq      (ch.seq[i*SEQ_W +: SEQ_W]),
            .load_pc       (ch.pc[i*XLEN +: XLEN]),
            .load_rd       (ch.rd[i*5 +: 5]),
            .load_dest_wen (ch.dest_wen[i]),
            .load_data     (ch.data[i*XLEN +: XLEN]),
            .load_trap     (ch.trap_valid[i]),
            .load_cause    (ch.trap_cause[i*XLEN +: XLEN]),
            .hold_v        (hold_v[i]),
            .seq           (slot_seq[i]),
            .pc            (slot_pc[i]),
            .rd            (slot_rd[i]),
            .dest_wen      (slot_dest_wen[i]),
            .data          (slot_data[i]),
            .trap          (slot_trap[i]),
            .cause         (slot_cause[i])
        );

        assign match[i] = hold_v[i] & (slot_seq[i] == exp_seq);
    end

    // Scan high to low so the lowest matching index is the last to write.
    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant        = '0;
        commit_valid = 1'b0;
        commit_pc    = '0;
        commit_trap  = 1'b0;
        commit_cause = '0;
        sel_dest_wen = 1'b0;
        sel_rd       = '0;
        sel_data     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (match[i]) begin
                grant        = '0;
                grant[i]     = 1'b1;
                commit_valid = 1'b1;
                commit_pc    = slot_pc[i];
                commit_trap  = slot_trap[i];
                commit_cause = slot_cause[i];
                sel_dest_wen = slot_dest_wen[i];
                sel_rd       = slot_rd[i];
                sel_data     = slot_data[i];
            end
        end
    end

    // x0 is hardwired to zero and a trapping instruction must not update state.
    assign gpr_wen   = commit_valid & sel_dest_wen & ~commit_trap & (sel_rd != 5'd0);
    assign gpr_rd    = sel_rd;
    assign gpr_wdata = sel_data;

    // A retire still advances the tag during a flush; the allocator restarts from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_seq <= '0;
        end else if (commit_valid) begin
            exp_seq <= exp_seq + 1'b1;
        end
    end

    logic [SYNC_STAGES:0][IRQ_NUM-1:0] irq_stage;

    assign irq_stage[0] = irq_asyn;

    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
        wbu_sync #(
            .WIDTH (IRQ_NUM)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (irq_stage[s]),
            .q     (irq_stage[s+1])
        );
    end

    assign irq_syn = irq_stage[SYNC_STAGES];

endmodule

// File: tb/tb_wbu_commit.sv
// Bench for wbu_commit: directed scenarios plus randomized traffic, checked
// every cycle against a tag-keyed scoreboard of accepted results.
module tb_wbu_commit;
    import wbu_commit_pkg::*;

    localparam int NUM_CH      = 2;
    localparam int SEQ_W       = 4;
    localparam int XLEN        = 64;
    localparam int IRQ_NUM     = 6;
    localparam int SYNC_STAGES = 2;
    localparam int SEQ_MOD     = 1 << SEQ_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               csr_jump_flag;
    logic [IRQ_NUM-1:0] irq_asyn;
    logic [IRQ_NUM-1:0] irq_syn;
    logic               gpr_wen;
    logic [4:0]         gpr_rd;
    logic [XLEN-1:0]    gpr_wdata;
    logic               commit_valid;
    logic [XLEN-1:0]    commit_pc;
    logic               commit_trap;
    logic [XLEN-1:0]    commit_cause;
    logic               flush_flag;
    logic [SEQ_W-1:0]   exp_seq;

    always #5 clk = ~clk;

    wbu_commit_if #(.NUM_CH(NUM_CH), .SEQ_W(SEQ_W), .XLEN(XLEN)) ch_if ();

    wbu_commit #(
        .NUM_CH      (NUM_CH),
        .SEQ_W       (SEQ_W),
        .XLEN        (XLEN),
        .IRQ_NUM     (IRQ_NUM),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch            (ch_if),
        .csr_jump_flag (csr_jump_flag),
        .irq_asyn      (irq_asyn),
        .irq_syn       (irq_syn),
        .gpr_wen       (gpr_wen),
        .gpr_rd        (gpr_rd),
        .gpr_wdata     (gpr_wdata),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_trap   (commit_trap),
        .commit_cause  (commit_cause),
        .flush_flag    (flush_flag),
        .exp_seq       (exp_seq)
    );

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            wen;
        logic [XLEN-1:0] data;
        logic            trap;
        logic [XLEN-1:0] cause;
        int              owner;
    } rec_t;

    // Scoreboard: accepted-but-unretired results keyed by tag.
    rec_t               pend [int];
    int                 m_exp;
    int                 next_alloc;
    logic [NUM_CH-1:0]  offer_v;
    int                 offer_tag [NUM_CH];
    rec_t               offer_rec [NUM_CH];
    logic               jump;
    logic [IRQ_NUM-1:0] irq;
    logic [IRQ_NUM-1:0] irq_hist [$];

    logic [NUM_CH-1:0]  e_ready;
    logic               e_ret;
    rec_t               e_rec;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic offer(input int i, input int tag, input logic [4:0] rd, input logic [XLEN-1:0] data,
                         input logic trap = 1'b0, input logic [XLEN-1:0] cause = '0, input logic wen = 1'b1);
        offer_v[i]         = 1'b1;
        offer_tag[i]       = tag;
        offer_rec[i].pc    = 64'h8000_0000 + 64'(tag) * 4;
        offer_rec[i].rd    = rd;
        offer_rec[i].wen   = wen;
        offer_rec[i].data  = data;
        offer_rec[i].trap  = trap;
        offer_rec[i].cause = cause;
        offer_rec[i].owner = i;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_if.valid[i]                  = offer_v[i];
            ch_if.seq[i*SEQ_W +: SEQ_W]     = SEQ_W'(offer_tag[i]);
            ch_if.pc[i*XLEN +: XLEN]        = offer_rec[i].pc;
            ch_if.rd[i*5 +: 5]              = offer_rec[i].rd;
            ch_if.dest_wen[i]               = offer_rec[i].wen;
            ch_if.data[i*XLEN +: XLEN]      = offer_rec[i].data;
            ch_if.trap_valid[i]             = offer_rec[i].trap;
            ch_if.trap_cause[i*XLEN +: XLEN] = offer_rec[i].cause;
        end
        csr_jump_flag = jump;
        irq_asyn      = irq;
    endtask

    task automatic clear_model();
        pend.delete();
        m_exp      = 0;
        next_alloc = 0;
        offer_v    = '0;
        irq_hist.delete();
    endtask

    // Apply this cycle's inputs and compare every meaningful output with the scoreboard.
    task automatic settle();
        logic busy;
        logic exp_wen;
        logic [IRQ_NUM-1:0] exp_irq;
        @(negedge clk);
        drive();
        #1;
        e_ret = pend.exists(m_exp);
        if (e_ret) e_rec = pend[m_exp];
        for (int i = 0; i < NUM_CH; i++) begin
            busy = 1'b0;
            foreach (pend[t]) if (pend[t].owner == i) busy = 1'b1;
            e_ready[i] = !jump && (!busy || (e_ret && e_rec.owner == i));
        end
        exp_wen = e_ret && e_rec.wen && !e_rec.trap && (e_rec.rd != 5'd0);
        exp_irq = (irq_hist.size() >= SYNC_STAGES) ? irq_hist[irq_hist.size() - SYNC_STAGES] : '0;
        check("ch_ready", ch_if.ready, e_ready);
        check("commit_valid", commit_valid, e_ret);
        check("flush_flag", flush_flag, jump);
        check("exp_seq", exp_seq, m_exp);
        check("gpr_wen", gpr_wen, exp_wen);
        check("irq_syn", irq_syn, exp_irq);
        if (e_ret) begin
            check("commit_pc", commit_pc, e_rec.pc);
            check("commit_trap", commit_trap, e_rec.trap);
            if (e_rec.trap) check("commit_cause", commit_cause, e_rec.cause);
        end
        if (exp_wen) begin
            check("gpr_rd", gpr_rd, e_rec.rd);
            check("gpr_wdata", gpr_wdata, e_rec.data);
        end
    endtask

    // Apply the coming clock edge to the scoreboard, then take the edge.
    task automatic advance();
        logic [NUM_CH-1:0] acc;
        acc = offer_v & e_ready;
        irq_hist.push_back(irq);
        if (irq_hist.size() > 8) void'(irq_hist.pop_front());
        if (e_ret) begin
            pend.delete(m_exp);
            m_exp = (m_exp + 1) % SEQ_MOD;
        end
        if (jump) pend.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i]) begin
                check("tag_unique", pend.exists(offer_tag[i]), 1'b0);
                pend[offer_tag[i]] = offer_rec[i];
                offer_v[i] = 1'b0;
            end
        end
        if (jump) begin
            offer_v    = '0;
            next_alloc = m_exp;
        end
        @(posedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        jump = 1'b0;
        drive();
        rst_n = 1'b0;
        #1;
        check({tag, "_commit_valid"}, commit_valid, 1'b0);
        check({tag, "_gpr_wen"}, gpr_wen, 1'b0);
        check({tag, "_gpr_rd"}, gpr_rd, 5'd0);
        check({tag, "_commit_pc"}, commit_pc, 64'd0);
        check({tag, "_commit_trap"}, commit_trap, 1'b0);
        check({tag, "_flush"}, flush_flag, 1'b0);
        check({tag, "_exp_seq"}, exp_seq, 4'd0);
        check({tag, "_irq_syn"}, irq_syn, 6'd0);
        check({tag, "_ch_ready"}, ch_if.ready, 2'b11);
        clear_model();
        drive();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic gen_random();
        for (int i = 0; i < NUM_CH; i++) begin
            if (!offer_v[i] && $urandom_range(0, 2) == 0) begin
                offer(i, next_alloc, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                      ($urandom_range(0, 7) == 0), 64'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                offer_rec[i].pc = {$urandom, $urandom};
                next_alloc = (next_alloc + 1) % SEQ_MOD;
            end
        end
        jump = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0) irq[$urandom_range(0, IRQ_NUM - 1)] ^= 1'b1;
    endtask

    initial begin
        offer_v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            offer_tag[i] = 0;
            offer_rec[i] = '{pc: '0, rd: '0, wen: 1'b0, data: '0, trap: 1'b0, cause: '0, owner: i};
        end
        jump = 1'b0;
        irq  = '0;
        drive();
        do_reset("rst");

        // In order: seq0 then seq1, one GPR write per cycle.
        offer(0, 0, 5'd5, 64'h11);
        settle(); advance();
        offer(1, 1, 5'd6, 64'h22);
        settle();
        check("io_x5_wen", gpr_wen, 1'b1);
        check("io_x5_rd", gpr_rd, 5'd5);
        check("io_x5_data", gpr_wdata, 64'h11);
        check("io_exp0", exp_seq, 4'd0);
        advance();
        settle();
        check("io_x6_rd", gpr_rd, 5'd6);
        check("io_x6_data", gpr_wdata, 64'h22);
        check("io_exp1", exp_seq, 4'd1);
        advance();
        settle();
        check("io_exp2", exp_seq, 4'd2);
        check("io_idle", commit_valid, 1'b0);
        advance();

        // Out of order: younger tag on ch1 waits for the older tag on ch0.
        offer(1, 3, 5'd7, 64'h33);
        settle(); advance();
        offer(1, 4, 5'd8, 64'h44);
        settle();
        check("ooo_ch1_blocked", ch_if.ready[1], 1'b0);
        advance();
        settle(); advance();
        settle(); advance();
        offer(0, 2, 5'd9, 64'h55);
        settle(); advance();
        settle();
        check("ooo_first_rd", gpr_rd, 5'd9);
        check("ooo_first_data", gpr_wdata, 64'h55);
        advance();
        settle();
        check("ooo_second_rd", gpr_rd, 5'd7);
        advance();
        settle();
        check("ooo_reload_rd", gpr_rd, 5'd8);
        advance();

        // Write to x0 retires but never writes the register file.
        offer(0, 5, 5'd0, 64'h66);
        settle(); advance();
        settle();
        check("x0_commit_valid", commit_valid, 1'b1);
        check("x0_gpr_wen", gpr_wen, 1'b0);
        advance();

        // Back-to-back retires across the tag wrap.
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) offer(k % 2, (6 + k) % SEQ_MOD, 5'(10 + k % 8), 64'(k));
            settle();
            if (k > 0) check("wrap_no_stall", commit_valid, 1'b1);
            advance();
        end
        settle();
        check("wrap_exp_seq", exp_seq, 4'd10);
        advance();

        // Trapping seq3 retires under a CSR redirect; held seq4 is dropped.
        do_reset("rst2");
        offer(0, 0, 5'd1, 64'h1); settle(); advance();
        offer(1, 1, 5'd2, 64'h2); settle(); advance();
        offer(0, 2, 5'd3, 64'h3); settle(); advance();
        offer(1, 4, 5'd4, 64'h4); settle(); advance();
        offer(0, 3, 5'd3, 64'hdead, 1'b1, CAUSE_ILLEGAL_INSN);
        settle(); advance();
        jump = 1'b1;
        settle();
        check("trap_commit_valid", commit_valid, 1'b1);
        check("trap_commit_trap", commit_trap, 1'b1);
        check("trap_cause", commit_cause, 64'd2);
        check("trap_gpr_wen", gpr_wen, 1'b0);
        check("trap_flush", flush_flag, 1'b1);
        advance();
        jump = 1'b0;
        settle();
        check("trap_exp_seq", exp_seq, 4'd4);
        check("trap_dropped", commit_valid, 1'b0);
        advance();

        // Interrupt line appears after exactly SYNC_STAGES edges.
        irq[IRQ_SSIP] = 1'b1;
        settle(); advance();
        settle();
        check("irq_after_1", irq_syn[IRQ_SSIP], 1'b0);
        advance();
        settle();
        check("irq_after_2", irq_syn[IRQ_SSIP], 1'b1);
        advance();

        // Randomized traffic with a reset in the middle.
        next_alloc = m_exp;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset("mid_rst");
            gen_random();
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
